shifter_unit: RTL and testbench

SHIFTER_UNIT -- requirements
Module: shifter_unit

---
 rtl/shifter_unit_if.sv | 9 +
 rtl/shifter_unit.sv | 25 ++
 tb/tb_shifter_unit.sv | 54 +++++
 3 files changed

// File: rtl/shifter_unit_if.sv
// shifter_unit_if: operand/result bundle for shifter_unit (IN, SHIFT, SHIFT_TYPE in; OUT back)
interface shifter_unit_if;
  logic [7:0] IN;
  logic [7:0] SHIFT;
  logic       SHIFT_TYPE;
  logic [7:0] OUT;
  modport master (output IN, SHIFT, SHIFT_TYPE, input OUT);
  modport slave  (input IN, SHIFT, SHIFT_TYPE, output OUT);
endinterface

// File: rtl/shifter_unit.sv
// shifter_unit: registered 8-bit shifter, SHIFT_TYPE 0 = logical left, 1 = arithmetic right
// Ports: CLK clock, RESET sync active-high clear of OUT,
//        bus.IN operand, bus.SHIFT amount 0..255, bus.SHIFT_TYPE select, bus.OUT result (1-cycle latency)
module shifter_unit (
  input  logic          CLK,
  input  logic          RESET,
  shifter_unit_if.slave bus
);
  logic [7:0] out_d, out_q;
  logic signed [7:0] asr;
  logic sat;
  // Kept in its own signed net so the ternary below cannot turn >>> into a logical shift.
  assign asr = $signed(bus.IN) >>> bus.SHIFT[2:0];
  // Any high amount bit means the distance is at least 8: everything is shifted out.
  assign sat = |bus.SHIFT[7:3];
  always_comb begin
    out_d = bus.SHIFT_TYPE ? (sat ? {8{bus.IN[7]}} : asr)
                           : (sat ? 8'h00 : bus.IN << bus.SHIFT[2:0]);
  end
  always_ff @(posedge CLK) begin
    if (RESET) out_q <= 8'h00;
    else       out_q <= out_d;
  end
  assign bus.OUT = out_q;
endmodule

// File: tb/tb_shifter_unit.sv
// tb_shifter_unit: directed self-checking bench for shifter_unit
module tb_shifter_unit;
  logic CLK, RESET;
  int checks = 0, errors = 0;
  shifter_unit_if bus ();
  shifter_unit dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] exp);
    checks++;
    assert (bus.OUT === exp) else begin
      errors++;
      $error("FAIL %s: OUT=%h expected=%h", tag, bus.OUT, exp);
    end
  endtask

  task automatic op(input logic r, input logic [7:0] in, input logic [7:0] sh, input logic t);
    RESET = r; bus.IN = in; bus.SHIFT = sh; bus.SHIFT_TYPE = t;
    @(posedge CLK); #1;
  endtask

  initial begin
    RESET = 1'b1; bus.IN = 8'h00; bus.SHIFT = 8'h00; bus.SHIFT_TYPE = 1'b0;
    @(negedge CLK);
    op(1, 8'h55, 8'd1, 0); chk("reset", 8'h00);
    op(0, 8'h55, 8'd1, 0); chk("first_after_reset", 8'hAA);
    op(0, 8'hFF, 8'd3, 1); chk("asr_neg1_s3", 8'hFF);
    op(0, 8'hFF, 8'd0, 1); chk("asr_neg1_s0", 8'hFF);
    op(0, 8'h15, 8'd1, 1); chk("asr_15_s1", 8'h0A);
    op(0, 8'h15, 8'd3, 1); chk("asr_15_s3", 8'h02);
    op(0, 8'h7F, 8'd3, 1); chk("asr_7f_s3", 8'h0F);
    op(0, 8'h80, 8'd1, 1); chk("asr_80_s1", 8'hC0);
    op(0, 8'h80, 8'd7, 1); chk("asr_80_s7", 8'hFF);
    op(0, 8'h15, 8'd1, 0); chk("lsl_15_s1", 8'h2A);
    op(0, 8'h15, 8'd3, 0); chk("lsl_15_s3", 8'hA8);
    op(0, 8'h15, 8'd0, 0); chk("lsl_15_s0", 8'h15);
    op(0, 8'h81, 8'd7, 0); chk("lsl_81_s7", 8'h80);
    op(0, 8'hAA, 8'd8, 1); chk("sat_asr_aa_s8", 8'hFF);
    op(0, 8'hAA, 8'd8, 0); chk("sat_lsl_aa_s8", 8'h00);
    op(0, 8'h55, 8'hFF, 1); chk("sat_asr_55_sff", 8'h00);
    op(0, 8'h01, 8'h09, 0); chk("sat_lsl_01_s9", 8'h00);
    op(0, 8'hAA, 8'h10, 1); chk("sat_asr_aa_s16", 8'hFF);
    op(0, 8'h15, 8'd1, 0); chk("pre_hold", 8'h2A);
    bus.IN = 8'h40; #3;
    chk("hold_mid_cycle", 8'h2A);
    @(posedge CLK); #1; chk("after_hold_edge", 8'h80);
    op(1, 8'hFF, 8'd3, 1); chk("reset_priority", 8'h00);
    op(0, 8'h33, 8'd2, 0); chk("first_after_reset2", 8'hCC);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
